soc_share_sequencer: RTL and testbench

- Multi-cycle controller that computes per-cell current shares i_k = I * w_k / (w1+w2+w3+w4) for four cells.
- Weights: w_k = soc_k when discharging (I > 0), w_k = 1/soc_k when charging (I < 0).
- All arithmetic is time-multiplexed onto one shared IEEE-754 single-precision FP unit (add, multiply, reciprocal) through a valid/ready request and response-valid handshake.
- Replaces the fully parallel share datapath in area-constrained builds; sits between the pack-current input and the per-cell current outputs.

---
 rtl/soc_share_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_soc_share_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_share_sequencer.sv
// Sequences per-cell current shares i_k = I * w_k / sum(w) onto one shared FP unit.
// Exactly one FP op is outstanding at a time; weights are reused in place as result registers.
module soc_share_sequencer #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] soc1,
  input  logic [XLEN-1:0] soc2,
  input  logic [XLEN-1:0] soc3,
  input  logic [XLEN-1:0] soc4,
  input  logic [XLEN-1:0] I,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] i1,
  output logic [XLEN-1:0] i2,
  output logic [XLEN-1:0] i3,
  output logic [XLEN-1:0] i4,
  output logic            fpu_req_valid,
  input  logic            fpu_req_ready,
  output logic [1:0]      fpu_op,
  output logic [XLEN-1:0] fpu_a,
  output logic [XLEN-1:0] fpu_b,
  input  logic            fpu_rsp_valid,
  input  logic [XLEN-1:0] fpu_result
);

  localparam logic [9:0] TO10 = 10'(TIMEOUT);
  localparam logic [1:0] OP_ADD = 2'b00, OP_MUL = 2'b01, OP_RCP = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_WRECIP, S_SUM, S_RDEN, S_SCALE, S_OUT, S_FIN} state_t;

  state_t          state_reg, state_next;
  logic            pend_reg, pend_next;
  logic [1:0]      k_reg, k_next;
  logic [9:0]      cnt_reg, cnt_next;
  logic            err_reg, err_next;
  logic [XLEN-1:0] cur_reg, acc_reg;
  logic [XLEN-1:0] w_reg [4];
  logic [XLEN-1:0] i_reg [4];
  logic            latch, complete, abort, load_i, zero_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pend_reg  <= 1'b0;
      k_reg     <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      cur_reg   <= '0;
      acc_reg   <= '0;
      for (int j = 0; j < 4; j++) begin
        w_reg[j] <= '0;
        i_reg[j] <= '0;
      end
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      k_reg     <= k_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      if (latch) begin
        cur_reg  <= I;
        w_reg[0] <= soc1;
        w_reg[1] <= soc2;
        w_reg[2] <= soc3;
        w_reg[3] <= soc4;
      end
      // Weights are overwritten by their own share once OUT multiplies them
      if (complete) begin
        if (state_reg == S_WRECIP || state_reg == S_OUT) w_reg[k_reg] <= fpu_result;
        else acc_reg <= fpu_result;
      end
      if (load_i) begin
        for (int j = 0; j < 4; j++)
          i_reg[j] <= zero_i ? '0 : ((j == 3) ? fpu_result : w_reg[j]);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    pend_next     = pend_reg;
    k_next        = k_reg;
    cnt_next      = cnt_reg;
    err_next      = err_reg;
    latch         = 1'b0;
    complete      = 1'b0;
    abort         = 1'b0;
    load_i        = 1'b0;
    zero_i        = 1'b0;
    fpu_req_valid = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          latch     = 1'b1;
          pend_next = 1'b0;
          k_next    = '0;
          err_next  = 1'b0;
          if (I[XLEN-2:0] == '0) begin
            state_next = S_FIN;
            load_i     = 1'b1;
            zero_i     = 1'b1;
          end else begin
            state_next = I[XLEN-1] ? S_WRECIP : S_SUM;
          end
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
        err_next   = 1'b0;
      end
      default: begin
        if (!pend_reg) begin
          if (state_reg == S_WRECIP && w_reg[k_reg][XLEN-2:0] == '0) begin
            abort = 1'b1;
          end else begin
            fpu_req_valid = 1'b1;
            if (fpu_req_ready) begin
              // The acceptance cycle is the first waiting cycle of the timeout window
              if (fpu_rsp_valid) complete = 1'b1;
              else if (TO10 == 10'd1) abort = 1'b1;
              else begin
                pend_next = 1'b1;
                cnt_next  = 10'd1;
              end
            end
          end
        end else begin
          if (fpu_rsp_valid) complete = 1'b1;
          else if (cnt_reg + 10'd1 == TO10) abort = 1'b1;
          else cnt_next = cnt_reg + 10'd1;
        end
        if (complete) begin
          pend_next = 1'b0;
          k_next    = 2'(k_reg + 2'd1);
          case (state_reg)
            S_WRECIP: if (k_reg == 2'd3) begin state_next = S_SUM; k_next = '0; end
            S_SUM:    if (k_reg == 2'd2) begin state_next = S_RDEN; k_next = '0; end
            S_RDEN:   begin state_next = S_SCALE; k_next = '0; end
            S_SCALE:  begin state_next = S_OUT; k_next = '0; end
            S_OUT:    if (k_reg == 2'd3) begin state_next = S_FIN; load_i = 1'b1; end
            default:  ;
          endcase
        end
        if (abort) begin
          state_next = S_FIN;
          pend_next  = 1'b0;
          err_next   = 1'b1;
          load_i     = 1'b1;
          zero_i     = 1'b1;
        end
      end
    endcase
  end

  // Operand selection depends only on registers, so it holds steady while stalled
  always_comb begin
    fpu_op = OP_ADD;
    fpu_a  = '0;
    fpu_b  = '0;
    case (state_reg)
      S_WRECIP: begin fpu_op = OP_RCP; fpu_b = w_reg[k_reg]; end
      S_SUM: begin
        fpu_op = OP_ADD;
        fpu_a  = (k_reg == 2'd0) ? w_reg[0] : acc_reg;
        fpu_b  = w_reg[2'(k_reg + 2'd1)];
      end
      S_RDEN:  begin fpu_op = OP_RCP; fpu_b = acc_reg; end
      S_SCALE: begin fpu_op = OP_MUL; fpu_a = cur_reg; fpu_b = acc_reg; end
      S_OUT:   begin fpu_op = OP_MUL; fpu_a = w_reg[k_reg]; fpu_b = acc_reg; end
      default: ;
    endcase
  end

  assign busy = (state_reg != S_IDLE) && (state_reg != S_FIN);
  assign done = (state_reg == S_FIN);
  assign err  = (state_reg == S_FIN) && err_reg;
  assign i1   = i_reg[0];
  assign i2   = i_reg[1];
  assign i3   = i_reg[2];
  assign i4   = i_reg[3];

endmodule

// File: tb/tb_soc_share_sequencer.sv
// Table-driven bench for soc_share_sequencer with a behavioural FP unit model
// (configurable stall, latency, no-response) plus hand-written reset/zero sequences.
module tb_soc_share_sequencer;

  logic        clk, rst, start;
  logic [31:0] soc1, soc2, soc3, soc4, cur;
  logic        busy, done, err;
  logic [31:0] i1, i2, i3, i4;
  logic        fpu_req_valid, fpu_req_ready, fpu_rsp_valid;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b, fpu_result;

  soc_share_sequencer #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .soc1(soc1), .soc2(soc2), .soc3(soc3), .soc4(soc4), .I(cur),
    .busy(busy), .done(done), .err(err),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4),
    .fpu_req_valid(fpu_req_valid), .fpu_req_ready(fpu_req_ready),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_rsp_valid(fpu_rsp_valid), .fpu_result(fpu_result)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  // FP model controls (written by the main sequence only)
  int stall_target = 0;
  int fixed_lat = 2;
  bit rand_lat = 0;
  bit noresp = 0;

  // FP model log (written by the model only)
  int          req_n = 0;
  int          acc_cyc = 0;
  logic [1:0]  log_op [256];
  logic [31:0] log_res [256];

  typedef struct {
    logic [31:0] s1, s2, s3, s4, cur;
    int          stall, lat;
    bit          noresp, ign, tout;
    logic [31:0] e1, e2, e3, e4, den;
    int          n;
    bit          err;
  } vec_t;
  vec_t tbl [7];

  function automatic vec_t mk(input logic [31:0] s1, s2, s3, s4, c, input int stall, lat,
                              input bit nr, ign, tout, input logic [31:0] e1, e2, e3, e4, den,
                              input int n, input bit e);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.s3 = s3; v.s4 = s4; v.cur = c;
    v.stall = stall; v.lat = lat; v.noresp = nr; v.ign = ign; v.tout = tout;
    v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4; v.den = den; v.n = n; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic        s;
    real         a;
    int          e;
    logic [31:0] m;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    while (a >= 2.0 && e < 254) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
    m = 32'($rtoi((a - 1.0) * 8388608.0 + 0.5));
    return {s, 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] fpu_calc(input logic [1:0] op, input logic [31:0] a, b);
    case (op)
      2'b00:   return r2f(f2r(a) + f2r(b));
      2'b01:   return r2f(f2r(a) * f2r(b));
      2'b10:   return (b[30:0] == 31'd0) ? 32'h7F800000 : r2f(1.0 / f2r(b));
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  // FP unit model: decides ready/response on the falling edge
  initial begin
    bit          pending, prev_stall, outstanding;
    int          dly, stall_cnt, lat;
    logic [31:0] held, res, prev_a, prev_b;
    logic [1:0]  prev_op;
    pending = 0; prev_stall = 0; dly = 0; stall_cnt = 0; held = '0;
    prev_a = '0; prev_b = '0; prev_op = '0;
    fpu_req_ready = 1'b0; fpu_rsp_valid = 1'b0; fpu_result = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && !rst)
        check("req_hold", {fpu_req_valid, fpu_op, fpu_a, fpu_b}, {1'b1, prev_op, prev_a, prev_b});
      if (rst) begin
        prev_stall = 0;
        stall_cnt  = 0;
      end
      outstanding   = pending;
      fpu_rsp_valid = 1'b0;
      if (pending) begin
        if (dly == 0) begin
          fpu_rsp_valid = 1'b1;
          fpu_result    = held;
          pending       = 0;
        end else dly--;
      end
      fpu_req_ready = 1'b0;
      if (fpu_req_valid && !rst) begin
        if (stall_cnt < stall_target) stall_cnt++;
        else begin
          fpu_req_ready = 1'b1;
          stall_cnt     = 0;
        end
      end
      if (fpu_req_valid && fpu_req_ready) begin
        check("one_outstanding", outstanding, 0);
        res = fpu_calc(fpu_op, fpu_a, fpu_b);
        if (req_n < 256) begin
          log_op[req_n]  = fpu_op;
          log_res[req_n] = res;
        end
        req_n++;
        acc_cyc = cyc;
        lat = rand_lat ? int'($urandom_range(7, 0)) : fixed_lat;
        if (!noresp) begin
          if (lat == 0) begin
            fpu_rsp_valid = 1'b1;
            fpu_result    = res;
          end else begin
            pending = 1;
            dly     = lat - 1;
            held    = res;
          end
        end
      end
      prev_stall = fpu_req_valid && !fpu_req_ready;
      prev_op = fpu_op; prev_a = fpu_a; prev_b = fpu_b;
    end
  end

  task automatic run_row(input int r);
    vec_t       v;
    int         n0, pre, m;
    logic [1:0] eop;
    bit         got;
    v = tbl[r];
    stall_target = v.stall;
    rand_lat     = (v.lat < 0);
    fixed_lat    = (v.lat < 0) ? 0 : v.lat;
    noresp       = v.noresp;
    @(posedge clk); #1;
    soc1 = v.s1; soc2 = v.s2; soc3 = v.s3; soc4 = v.s4; cur = v.cur;
    start = 1'b1;
    n0 = req_n;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int it = 0; it < 600 && !got; it++) begin
      @(negedge clk);
      if (it == 0) check("busy_after_start", busy, 1);
      if (done) got = 1;
      else if (v.ign && it == 10) begin
        start = 1'b1; cur = 32'h0; soc1 = 32'h40400000;
      end else start = 1'b0;
    end
    start = 1'b0;
    check("done_seen", got, 1);
    check("err_at_done", err, v.err);
    check("busy_at_done", busy, 0);
    check("i1", i1, v.e1);
    check("i2", i2, v.e2);
    check("i3", i3, v.e3);
    check("i4", i4, v.e4);
    check("req_count", req_n - n0, v.n);
    if (v.tout) check("timeout_cycles", cyc - acc_cyc, 8);
    pre = v.cur[31] ? 4 : 0;
    for (int j = 0; j < v.n && n0 + j < 256; j++) begin
      m   = j - pre;
      eop = (j < pre || m == 3) ? 2'b10 : ((m < 3) ? 2'b00 : 2'b01);
      check("op_order", log_op[n0 + j], eop);
    end
    if (!v.err && n0 + pre + 2 < 256) check("den", log_res[n0 + pre + 2], v.den);
    $display("run %0d: i=%h %h %h %h err=%0d reqs=%0d", r, i1, i2, i3, i4, err, req_n - n0);
    @(negedge clk);
    check("done_single_pulse", done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, d0;
    bit hit;
    tbl[0] = mk(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h40800000, 0, 2, 0, 0, 0,
                32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 9, 0);
    tbl[1] = mk(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'hC0000000, 0, 2, 0, 0, 0,
                32'hBF000000, 32'hBF000000, 32'hBF000000, 32'hBF000000, 32'h41000000, 13, 0);
    tbl[2] = mk(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h40800000, 5, -1, 0, 1, 0,
                32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 9, 0);
    tbl[3] = mk(32'h3F000000, 32'h3F000000, 32'h00000000, 32'h3F000000, 32'hC0000000, 0, 2, 0, 0, 0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1);
    tbl[4] = mk(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h40800000, 0, 2, 1, 0, 1,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1);
    tbl[5] = mk(32'h3E800000, 32'h3E800000, 32'h3F000000, 32'h3F800000, 32'h41000000, 1, 7, 0, 0, 0,
                32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40800000, 32'h40000000, 9, 0);
    tbl[6] = mk(32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h3E800000, 32'hC1000000, 0, 0, 0, 0, 0,
                32'hBF800000, 32'hBF800000, 32'hC0000000, 32'hC0800000, 32'h41000000, 13, 0);

    rst = 1'b1; start = 1'b0;
    soc1 = '0; soc2 = '0; soc3 = '0; soc4 = '0; cur = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_req_valid", fpu_req_valid, 0);
    check("rst_i", {i1, i2}, 64'h0);
    check("rst_i34", {i3, i4}, 64'h0);
    check("rst_operands", {fpu_op, fpu_a, fpu_b}, 66'h0);

    for (int r = 0; r < 7; r++) run_row(r);

    // Zero current with stale outputs from the previous run
    stall_target = 0; fixed_lat = 2; rand_lat = 0; noresp = 0;
    n0 = req_n;
    @(posedge clk); #1;
    soc1 = 32'h3F000000; soc2 = 32'h3F000000; soc3 = 32'h3F000000; soc4 = 32'h3F000000;
    cur = 32'h80000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_err", err, 0);
    check("zero_i", {i1, i2, i3, i4}, 128'h0);
    @(negedge clk);
    check("zero_done_pulse", done, 0);
    check("zero_busy_after", busy, 0);
    check("zero_no_req", req_n - n0, 0);
    $display("zero run: done seen, i=%h %h %h %h reqs=%0d", i1, i2, i3, i4, req_n - n0);

    // Reset while the scale multiply is outstanding; its late response must be ignored
    run_row(0);
    fixed_lat = 5;
    @(posedge clk); #1;
    soc1 = 32'h3F000000; soc2 = 32'h3F000000; soc3 = 32'h3F000000; soc4 = 32'h3F000000;
    cur = 32'h40800000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int it = 0; it < 300 && !hit; it++) begin
      @(negedge clk);
      if (fpu_req_valid && fpu_op == 2'b01) hit = 1;
    end
    check("scale_reached", hit, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_req_valid", fpu_req_valid, 0);
    check("midrst_i", {i1, i2, i3, i4}, 128'h0);
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    check("stray_rsp_no_done", done_cnt - d0, 0);
    $display("mid-run reset: outputs cleared, stray response ignored");
    run_row(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
